// File: rtl/operand_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : operand_feeder_if
// Description : Bundles the row-load handshake, the operand outputs to the
//               scalar product pipe and the result tag of operand_feeder.
//               master : upstream / collector side (drives load_valid/data)
//               slave  : operand_feeder side
// Signals     : load_valid, load_ready, load_data[4*NBITS]
//               A_out[4*NBITS], B_out[4*NBITS], issue_valid, issue_idx[4]
//               res_valid, res_idx[4], done
// Revision    : 1.0 - initial release
// ============================================================================
interface operand_feeder_if #(
    parameter int NBITS = 8
);
    logic                 load_valid;
    logic                 load_ready;
    logic [4*NBITS-1:0]   load_data;
    logic [4*NBITS-1:0]   A_out;
    logic [4*NBITS-1:0]   B_out;
    logic                 issue_valid;
    logic [3:0]           issue_idx;
    logic                 res_valid;
    logic [3:0]           res_idx;
    logic                 done;

    modport master (
        output load_valid, load_data,
        input  load_ready, A_out, B_out, issue_valid, issue_idx,
               res_valid, res_idx, done
    );

    modport slave (
        input  load_valid, load_data,
        output load_ready, A_out, B_out, issue_valid, issue_idx,
               res_valid, res_idx, done
    );
endinterface
`default_nettype wire

// File: rtl/operand_feeder.sv
`default_nettype none
// ============================================================================
// Module      : operand_feeder
// Description : Buffers two 4x4 operand matrices (A rows on beats 0-3, B rows
//               on beats 4-7) and streams the 16 (row A_i, column B_j) pairs
//               into the 4-lane scalar product pipe in row-major order. A tag
//               delayed by PIPE_LAT marks which C[i][j] leaves the pipe.
// Ports       : clk   - clock, rising edge
//               reset - asynchronous, active-low
//               bus   - operand_feeder_if.slave (load handshake, operands,
//                       issue tag, result tag, done pulse)
// Revision    : 1.0 - initial release
// ============================================================================
module operand_feeder #(
    parameter int NBITS    = 8,
    parameter int PIPE_LAT = 4
) (
    input  logic            clk,
    input  logic            reset,
    operand_feeder_if.slave bus
);
    localparam logic [3:0] c_LAST_IDX  = 4'd15;
    localparam logic [2:0] c_LAST_BEAT = 3'd7;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [2:0]           r_beat;
    logic [4*NBITS-1:0]   r_a_mem [4];
    logic [4*NBITS-1:0]   r_b_mem [4];

    logic                 r_load_ready;
    logic [4*NBITS-1:0]   r_a_out;
    logic [4*NBITS-1:0]   r_b_out;
    logic                 r_issue_valid;
    logic [3:0]           r_issue_idx;
    logic [PIPE_LAT-1:0]  r_dly_valid;
    logic [3:0]           r_dly_idx [PIPE_LAT];
    logic                 r_done;

    logic                 w_accept;
    logic                 w_last_beat;
    logic                 w_load_ready_next;
    logic                 w_issue_valid_next;
    logic [3:0]           w_sel_idx;
    logic [4*NBITS-1:0]   w_b_row3;
    logic [4*NBITS-1:0]   w_a_sel;
    logic [4*NBITS-1:0]   w_b_sel;
    logic                 w_tail_valid_next;
    logic [3:0]           w_tail_idx_next;

    assign w_accept    = (r_state == ST_LOAD) && r_load_ready && bus.load_valid;
    assign w_last_beat = w_accept && (r_beat == c_LAST_BEAT);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and next registered-output values
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next       = r_state;
        w_load_ready_next  = 1'b0;
        w_issue_valid_next = 1'b0;
        w_sel_idx          = 4'd0;
        case (r_state)
            ST_LOAD: begin
                w_load_ready_next = 1'b1;
                if (w_last_beat) begin
                    // Pair 0 goes out on the same edge that takes B row 3.
                    w_state_next       = ST_ISSUE;
                    w_load_ready_next  = 1'b0;
                    w_issue_valid_next = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (r_issue_idx != c_LAST_IDX) begin
                    w_issue_valid_next = 1'b1;
                    w_sel_idx          = r_issue_idx + 4'd1;
                end else begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Leave one cycle after done so ready rises right after it.
                if (r_done) begin
                    w_state_next      = ST_LOAD;
                    w_load_ready_next = 1'b1;
                end
            end
            default: w_state_next = ST_LOAD;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand selection. B row 3 is bypassed from load_data because it is
    // written on the same edge that registers pair 0.
    // ------------------------------------------------------------------
    always_comb begin
        w_b_row3 = w_last_beat ? bus.load_data : r_b_mem[3];
        w_a_sel  = '0;
        w_b_sel  = '0;
        if (w_issue_valid_next) begin
            w_a_sel = r_a_mem[w_sel_idx[3:2]];
            for (int k = 0; k < 3; k++) begin
                w_b_sel[k*NBITS +: NBITS] = r_b_mem[k][w_sel_idx[1:0]*NBITS +: NBITS];
            end
            w_b_sel[3*NBITS +: NBITS] = w_b_row3[w_sel_idx[1:0]*NBITS +: NBITS];
        end
    end

    // Operand storage carries no reset; its contents are irrelevant until loaded.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            if (r_beat[2]) begin
                r_b_mem[r_beat[1:0]] <= bus.load_data;
            end else begin
                r_a_mem[r_beat[1:0]] <= bus.load_data;
            end
        end
    end

    // Input of the last delay stage, used to align done with res_valid.
    generate
        if (PIPE_LAT == 1) begin : g_tail_direct
            assign w_tail_valid_next = r_issue_valid;
            assign w_tail_idx_next   = r_issue_idx;
        end else begin : g_tail_chain
            assign w_tail_valid_next = r_dly_valid[PIPE_LAT-2];
            assign w_tail_idx_next   = r_dly_idx[PIPE_LAT-2];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Counters, registered outputs and result-tag delay line
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_beat        <= 3'd0;
            r_load_ready  <= 1'b0;
            r_a_out       <= '0;
            r_b_out       <= '0;
            r_issue_valid <= 1'b0;
            r_issue_idx   <= 4'd0;
            r_dly_valid   <= '0;
            for (int s = 0; s < PIPE_LAT; s++) begin
                r_dly_idx[s] <= 4'd0;
            end
            r_done        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_beat <= r_beat + 3'd1;   // wraps to beat 0 after beat 7
            end
            r_load_ready   <= w_load_ready_next;
            r_a_out        <= w_a_sel;
            r_b_out        <= w_b_sel;
            r_issue_valid  <= w_issue_valid_next;
            r_issue_idx    <= w_sel_idx;
            r_dly_valid[0] <= r_issue_valid;
            r_dly_idx[0]   <= r_issue_idx;
            for (int s = 1; s < PIPE_LAT; s++) begin
                r_dly_valid[s] <= r_dly_valid[s-1];
                r_dly_idx[s]   <= r_dly_idx[s-1];
            end
            r_done <= w_tail_valid_next && (w_tail_idx_next == c_LAST_IDX);
        end
    end

    assign bus.load_ready  = r_load_ready;
    assign bus.A_out       = r_a_out;
    assign bus.B_out       = r_b_out;
    assign bus.issue_valid = r_issue_valid;
    assign bus.issue_idx   = r_issue_idx;
    assign bus.res_valid   = r_dly_valid[PIPE_LAT-1];
    assign bus.res_idx     = r_dly_idx[PIPE_LAT-1];
    assign bus.done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_operand_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_feeder
// Description : Self-checking bench for operand_feeder. A timeline model
//               (job start edge + fixed offsets) predicts every output each
//               cycle; a behavioural 4-lane scalar product pipe checks the
//               end-to-end C[i][j] values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_feeder;
    localparam int NBITS    = 8;
    localparam int PIPE_LAT = 4;
    localparam int W        = 4 * NBITS;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    operand_feeder_if #(.NBITS(NBITS)) bus ();

    operand_feeder #(.NBITS(NBITS), .PIPE_LAT(PIPE_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: one job = 8 accepted beats. If beat 7 lands on edge
    // c, pair n is issued after edge c+n, its result after c+n+PIPE_LAT,
    // done after c+15+PIPE_LAT, and loading reopens one edge later.
    // ------------------------------------------------------------------
    int         e_cnt          = 0;
    int         ready_from     = 1;
    int         last_beat_edge = -1000;
    int         m_beats        = 0;
    logic [W-1:0] m_rows [8];
    logic [W-1:0] job_a  [4];
    logic [W-1:0] job_b  [4];

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                e_cnt          = 0;
                ready_from     = 1;
                last_beat_edge = -1000;
                m_beats        = 0;
            end else begin
                if (bus.load_valid && (e_cnt >= ready_from)) begin
                    m_rows[m_beats] = bus.load_data;
                    m_beats++;
                end
                e_cnt++;
                if (m_beats == 8) begin
                    for (int k = 0; k < 4; k++) begin
                        job_a[k] = m_rows[k];
                        job_b[k] = m_rows[4+k];
                    end
                    last_beat_edge = e_cnt;
                    ready_from     = e_cnt + 16 + PIPE_LAT;
                    m_beats        = 0;
                end
            end
        end
    end

    function automatic logic [W-1:0] exp_bcol(input int j);
        logic [W-1:0] r;
        for (int k = 0; k < 4; k++) r[k*NBITS +: NBITS] = job_b[k][j*NBITS +: NBITS];
        return r;
    endfunction

    function automatic logic [2*NBITS-1:0] exp_c(input int idx);
        int s;
        s = 0;
        for (int k = 0; k < 4; k++)
            s += int'(job_a[idx/4][k*NBITS +: NBITS]) * int'(job_b[k][(idx%4)*NBITS +: NBITS]);
        return (2*NBITS)'(s);
    endfunction

    // Behavioural scalar product pipe fed by the DUT operands.
    function automatic logic [2*NBITS-1:0] dot4(input logic [W-1:0] a, input logic [W-1:0] b);
        int s;
        s = 0;
        for (int k = 0; k < 4; k++) s += int'(a[k*NBITS +: NBITS]) * int'(b[k*NBITS +: NBITS]);
        return (2*NBITS)'(s);
    endfunction

    logic [2*NBITS-1:0] pipe [PIPE_LAT];
    always @(posedge clk) begin
        pipe[0] <= dot4(bus.A_out, bus.B_out);
        for (int p = 1; p < PIPE_LAT; p++) pipe[p] <= pipe[p-1];
    end

    // ------------------------------------------------------------------
    // Per-cycle compare against the model
    // ------------------------------------------------------------------
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("rst_load_ready", bus.load_ready, 0);
                check("rst_issue_valid", bus.issue_valid, 0);
                check("rst_issue_idx", bus.issue_idx, 0);
                check("rst_res_valid", bus.res_valid, 0);
                check("rst_res_idx", bus.res_idx, 0);
                check("rst_done", bus.done, 0);
                check("rst_A_out", bus.A_out, 0);
                check("rst_B_out", bus.B_out, 0);
            end else begin
                int d;
                d = e_cnt - last_beat_edge;
                check("load_ready", bus.load_ready, e_cnt >= ready_from);
                check("issue_valid", bus.issue_valid, d >= 0 && d < 16);
                if (d >= 0 && d < 16) begin
                    check("issue_idx", bus.issue_idx, d);
                    check("A_out", bus.A_out, job_a[d/4]);
                    check("B_out", bus.B_out, exp_bcol(d % 4));
                end else begin
                    check("A_out_idle", bus.A_out, 0);
                    check("B_out_idle", bus.B_out, 0);
                end
                check("res_valid", bus.res_valid, d >= PIPE_LAT && d < 16 + PIPE_LAT);
                if (d >= PIPE_LAT && d < 16 + PIPE_LAT) begin
                    check("res_idx", bus.res_idx, d - PIPE_LAT);
                    check("pipe_result", pipe[PIPE_LAT-1], exp_c(d - PIPE_LAT));
                end
                check("done", bus.done, d == 15 + PIPE_LAT);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [W-1:0] rowq [$];

    // Offers rowq in order; returns on the negedge right after the edge that
    // accepted the last row, with load_valid dropped.
    task automatic drive_rows(input int stall_pct);
        int drv   = 0;
        int guard = 0;
        bit pv    = 1'b0;
        bit pr    = 1'b0;
        while (drv < rowq.size()) begin
            @(negedge clk);
            if (pv && pr) drv++;
            guard++;
            if (guard > 400) begin
                vectors++;
                miscompares++;
                $display("FAIL load_timeout: got %0d beats expected %0d", drv, rowq.size());
                break;
            end
            if (drv < rowq.size()) begin
                bus.load_valid = ($urandom_range(99) >= stall_pct);
                bus.load_data  = rowq[drv];
            end else begin
                bus.load_valid = 1'b0;
                bus.load_data  = $urandom;
            end
            pv = bus.load_valid;
            pr = bus.load_ready;
        end
        bus.load_valid = 1'b0;
    endtask

    task automatic random_job(input int rows);
        rowq = {};
        for (int r = 0; r < rows; r++) rowq.push_back($urandom);
    endtask

    initial begin
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        reset          = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Basic order with hand-computed pins.
        rowq = {32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404,
                32'h04030201, 32'h04030201, 32'h04030201, 32'h04030201};
        drive_rows(0);
        check("lit_first_issue", bus.issue_valid, 1);
        check("lit_idx0_A", bus.A_out, 32'h01010101);
        check("lit_idx0_B", bus.B_out, 32'h01010101);
        @(negedge clk);
        check("lit_idx1_B", bus.B_out, 32'h02020202);
        repeat (4) @(negedge clk);
        check("lit_idx5_idx", bus.issue_idx, 5);
        check("lit_idx5_A", bus.A_out, 32'h02020202);
        check("lit_model_c15", exp_c(15), 16'd64);
        repeat (25) @(negedge clk);

        // Same job with random load stalls.
        drive_rows(50);
        repeat (25) @(negedge clk);

        // Back-to-back jobs with load_valid held high.
        random_job(16);
        drive_rows(0);
        repeat (25) @(negedge clk);

        // Random jobs with random stalls.
        for (int n = 0; n < 3; n++) begin
            random_job(8);
            drive_rows($urandom_range(60));
            repeat ($urandom_range(18, 30)) @(negedge clk);
        end

        // All elements 0xFF: result truncates to 16 bits.
        rowq = {};
        for (int r = 0; r < 8; r++) rowq.push_back(32'hFFFFFFFF);
        drive_rows(0);
        repeat (15 + PIPE_LAT) @(negedge clk);
        check("lit_ff_done", bus.done, 1);
        check("lit_ff_res_idx", bus.res_idx, 15);
        check("lit_ff_pipe", pipe[PIPE_LAT-1], 16'hF804);
        check("lit_ff_model", exp_c(15), 16'hF804);
        repeat (5) @(negedge clk);

        // Reset in the middle of ISSUE at idx 7.
        random_job(8);
        drive_rows(0);
        repeat (7) @(negedge clk);
        check("lit_mid_idx7", bus.issue_idx, 7);
        #2 reset = 1'b0;
        #1;
        check("async_issue_valid", bus.issue_valid, 0);
        check("async_A_out", bus.A_out, 0);
        check("async_B_out", bus.B_out, 0);
        check("async_res_valid", bus.res_valid, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("lit_ready_after_rst", bus.load_ready, 1);

        // Fresh job after the reset restarts at beat 0.
        random_job(8);
        drive_rows(30);
        repeat (25) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
